// File: rtl/player_pkg.sv
// Shared definitions for the player sprite: vertical motion states, animation
// direction codes and screen/sprite geometry also used by the draw stage.
package player_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } vstate_e;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_AIR   = 2'b11
  } anim_dir_e;

  localparam int BORDER       = 10;
  localparam int SCREEN_X_END = 1429;
  localparam int SCREEN_Y_END = 889;
  localparam int SPRITE_W     = 33;
  localparam int SPRITE_H     = 20;

  localparam int BTN_W     = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_CTR   = 4;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Frame-tick/button inputs and sprite position outputs of the motion controller.
interface player_motion_ctrl_if;
  logic        frame_tick;
  logic [4:0]  btn;
  logic [10:0] blkpos_x;
  logic [9:0]  blkpos_y;
  logic [1:0]  anim_dir;
  logic        moving;

  modport master (output frame_tick, btn, input blkpos_x, blkpos_y, anim_dir, moving);
  modport slave  (input frame_tick, btn, output blkpos_x, blkpos_y, anim_dir, moving);
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous push-button inputs.
module btn_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-locked sprite motion: horizontal walking with wall clamping and a
// ground/rise/fall jump with integer gravity, advanced once per frame_tick.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int X_MIN   = BORDER,
  parameter int X_MAX   = SCREEN_X_END - SPRITE_W + 1,
  parameter int Y_MIN   = BORDER,
  parameter int Y_FLOOR = SCREEN_Y_END - SPRITE_H + 1,
  parameter int X_START = 700,
  parameter int STEP_X  = 4,
  parameter int JUMP_V  = 12,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  player_motion_ctrl_if.slave  bus
);

  function automatic logic [11:0] sat_dec(input logic [11:0] a, input logic [11:0] d,
                                          input logic [11:0] lo);
    return (a < lo + d) ? lo : a - d;
  endfunction

  function automatic logic [11:0] sat_inc(input logic [11:0] a, input logic [11:0] d,
                                          input logic [11:0] hi);
    return (a + d > hi) ? hi : a + d;
  endfunction

  function automatic logic [5:0] sat_top(input logic [5:0] a, input logic [5:0] hi);
    return (a > hi) ? hi : a;
  endfunction

  logic [BTN_W-1:0] bs;

  btn_sync #(.WIDTH(BTN_W)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.btn),
    .q_o (bs)
  );

  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic [4:0]  vy_q;
  vstate_e     st_q;
  logic [1:0]  dir_q;
  logic        mv_q;

  logic [11:0] x_d, y_d, y_cur;
  logic [4:0]  vy_d, vy_rise;
  logic [5:0]  g_fall, v_fall;
  vstate_e     st_d;
  anim_dir_e   dir_d;
  logic        mv_d, left, right;

  always_comb begin
    left    = bs[BTN_LEFT] & ~bs[BTN_RIGHT];
    right   = bs[BTN_RIGHT] & ~bs[BTN_LEFT];
    x_d     = {1'b0, x_q};
    y_cur   = {2'b0, y_q};
    y_d     = y_cur;
    vy_d    = vy_q;
    st_d    = st_q;
    vy_rise = vy_q - 5'(GRAVITY);
    g_fall  = bs[BTN_DOWN] ? 6'(2 * GRAVITY) : 6'(GRAVITY);
    v_fall  = sat_top({1'b0, vy_q} + g_fall, 6'(V_MAX));

    if (left)       x_d = sat_dec({1'b0, x_q}, 12'(STEP_X), 12'(X_MIN));
    else if (right) x_d = sat_inc({1'b0, x_q}, 12'(STEP_X), 12'(X_MAX));

    case (st_q)
      ST_GROUND: begin
        // The take-off tick only loads the velocity; the sprite rises from the next tick.
        if (bs[BTN_UP]) begin
          st_d = ST_RISE;
          vy_d = 5'(JUMP_V);
        end else begin
          y_d = 12'(Y_FLOOR);
        end
      end
      ST_RISE: begin
        if (y_cur < 12'(Y_MIN) + {7'b0, vy_q}) begin
          y_d  = 12'(Y_MIN);
          vy_d = '0;
          st_d = ST_FALL;
        end else begin
          y_d  = y_cur - {7'b0, vy_q};
          vy_d = vy_rise;
          if (vy_rise == '0) st_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (y_cur + {6'b0, v_fall} >= 12'(Y_FLOOR)) begin
          y_d  = 12'(Y_FLOOR);
          vy_d = '0;
          st_d = ST_GROUND;
        end else begin
          y_d  = y_cur + {6'b0, v_fall};
          vy_d = v_fall[4:0];
        end
      end
      default: begin
        y_d  = 12'(Y_FLOOR);
        vy_d = '0;
        st_d = ST_GROUND;
      end
    endcase

    if (st_d != ST_GROUND) dir_d = DIR_AIR;
    else if (left)         dir_d = DIR_LEFT;
    else if (right)        dir_d = DIR_RIGHT;
    else                   dir_d = DIR_IDLE;

    if (bs[BTN_CTR]) begin
      x_d   = 12'(X_START);
      y_d   = 12'(Y_FLOOR);
      vy_d  = '0;
      st_d  = ST_GROUND;
      dir_d = DIR_IDLE;
    end

    mv_d = (x_d != {1'b0, x_q}) || (y_d != y_cur);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= 11'(X_START);
      y_q   <= 10'(Y_FLOOR);
      vy_q  <= '0;
      st_q  <= ST_GROUND;
      dir_q <= DIR_IDLE;
      mv_q  <= 1'b0;
    end else if (bus.frame_tick) begin
      x_q   <= x_d[10:0];
      y_q   <= y_d[9:0];
      vy_q  <= vy_d;
      st_q  <= st_d;
      dir_q <= dir_d;
      mv_q  <= mv_d;
    end
  end

  assign bus.blkpos_x = x_q;
  assign bus.blkpos_y = y_q;
  assign bus.anim_dir = dir_q;
  assign bus.moving   = mv_q;

endmodule
